// File: rtl/draw_menu_char.sv
// draw_menu_char: text-menu overlay with font addressing, blinking
// cursor highlight and a confirm handshake to game control.
//   pclk, rst         : pixel clock, sync active-high reset
//   vga_in / vga_out  : {hcount,vcount,hsync,vsync,hblnk,vblnk,rgb}, 2-cycle delay
//   char_xy/char_line : font ROM address (combinational)
//   char_pixels       : font ROM row, one cycle after the address
//   btn_up/down/sel   : single-cycle button pulses
//   sel_idx/sel_valid : confirmed entry and its one-cycle strobe
module draw_menu_char #(
  parameter int          XPOS         = 100,
  parameter int          YPOS         = 250,
  parameter int          COLS_W       = 4,
  parameter int          ROWS_W       = 4,
  parameter int          ENTRIES      = 2,
  parameter int          ROW_STRIDE   = 6,
  parameter logic [11:0] FG           = 12'hfff,
  parameter logic [11:0] HL           = 12'hff0,
  parameter int          BLINK_FRAMES = 32,
  parameter int          HOLD_FRAMES  = 60,
  localparam int         VGA_BUS_SIZE = 38,
  localparam int         SW           = $clog2(ENTRIES)
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [VGA_BUS_SIZE-1:0]    vga_in,
  input  logic [7:0]                 char_pixels,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_sel,
  output logic [COLS_W+ROWS_W-1:0]   char_xy,
  output logic [3:0]                 char_line,
  output logic [SW-1:0]              sel_idx,
  output logic                       sel_valid,
  output logic [VGA_BUS_SIZE-1:0]    vga_out
);

  localparam int FW  = $clog2(BLINK_FRAMES);
  localparam int HCW = $clog2(HOLD_FRAMES + 1);
  localparam int RW  = ROWS_W + 4;
  localparam logic [SW-1:0] LAST = SW'(ENTRIES - 1);

  typedef enum logic {BROWSE, CONFIRMED} state_t;

  logic [10:0] hrel, vrel;
  logic        in_box;
  logic        vblnk_rise;

  logic [VGA_BUS_SIZE-1:0] bus1_q;
  logic [2:0]              hpix1_q;
  logic                    inbox1_q;
  logic [ROWS_W-1:0]       row1_q;
  logic [VGA_BUS_SIZE-1:0] vga_out_d, vga_out_q;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_cur_q, sel_cur_d;
  logic [SW-1:0]   sel_disp_q, sel_disp_d;
  logic [SW-1:0]   sel_idx_q, sel_idx_d;
  logic            sel_valid_q, sel_valid_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic            hl_on;

  logic            pix_on;
  logic            paint;
  logic [RW-1:0]   hl_row;
  logic            row_hit;
  logic [11:0]     rgb2;

  // Wrapping subtraction pushes points left/above the window far out.
  assign hrel   = vga_in[37:27] - 11'(XPOS);
  assign vrel   = vga_in[26:16] - 11'(YPOS);
  assign in_box = ({1'b0, hrel} < 12'(8 * (2 ** COLS_W))) &&
                  ({1'b0, vrel} < 12'(16 * (2 ** ROWS_W)));

  assign char_xy   = {vrel[ROWS_W+3:4], hrel[COLS_W+2:3]};
  assign char_line = vrel[3:0];

  // Stage-1 copy of the bus doubles as the previous vblnk sample.
  assign vblnk_rise = vga_in[12] & ~bus1_q[12];

  always_ff @(posedge pclk) begin
    if (rst) begin
      bus1_q   <= '0;
      hpix1_q  <= '0;
      inbox1_q <= 1'b0;
      row1_q   <= '0;
    end else begin
      bus1_q   <= vga_in;
      hpix1_q  <= hrel[2:0];
      inbox1_q <= in_box;
      row1_q   <= vrel[ROWS_W+3:4];
    end
  end

  assign pix_on  = char_pixels[3'd7 - hpix1_q];
  assign paint   = inbox1_q & ~bus1_q[13] & ~bus1_q[12] & pix_on;
  assign hl_row  = RW'(sel_disp_q) * RW'(ROW_STRIDE);
  assign row_hit = ({4'b0, row1_q} == hl_row);
  assign rgb2    = paint ? ((row_hit && hl_on) ? HL : FG)
                         : bus1_q[11:0];
  assign vga_out_d = {bus1_q[37:12], rgb2};

  always_ff @(posedge pclk) begin
    if (rst) vga_out_q <= '0;
    else     vga_out_q <= vga_out_d;
  end

  always_comb begin
    state_d     = state_q;
    sel_cur_d   = sel_cur_q;
    sel_idx_d   = sel_idx_q;
    sel_valid_d = 1'b0;
    hold_d      = hold_q;
    hl_on       = 1'b1;
    case (state_q)
      BROWSE: begin
        hl_on = (fcnt_q < FW'(BLINK_FRAMES / 2));
        // Select wins over a same-cycle move.
        if (btn_sel) begin
          sel_idx_d   = sel_cur_q;
          sel_valid_d = 1'b1;
          hold_d      = '0;
          state_d     = CONFIRMED;
        end else if (btn_down && !btn_up) begin
          sel_cur_d = (sel_cur_q == LAST) ? '0 : sel_cur_q + 1'b1;
        end else if (btn_up && !btn_down) begin
          sel_cur_d = (sel_cur_q == '0) ? LAST : sel_cur_q - 1'b1;
        end
      end
      CONFIRMED: begin
        if (vblnk_rise) begin
          if (hold_q == HCW'(HOLD_FRAMES - 1)) state_d = BROWSE;
          else hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = BROWSE;
    endcase
  end

  always_comb begin
    sel_disp_d = sel_disp_q;
    fcnt_d     = fcnt_q;
    if (vblnk_rise) begin
      sel_disp_d = sel_cur_q;
      fcnt_d = (fcnt_q == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= BROWSE;
      sel_cur_q   <= '0;
      sel_disp_q  <= '0;
      sel_idx_q   <= '0;
      sel_valid_q <= 1'b0;
      fcnt_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_cur_q   <= sel_cur_d;
      sel_disp_q  <= sel_disp_d;
      sel_idx_q   <= sel_idx_d;
      sel_valid_q <= sel_valid_d;
      fcnt_q      <= fcnt_d;
      hold_q      <= hold_d;
    end
  end

  assign sel_idx   = sel_idx_q;
  assign sel_valid = sel_valid_q;
  assign vga_out   = vga_out_q;

endmodule
